rgf_uart_master: RTL and testbench

UART-to-register-bus bridge and the initiator for every register-file block on the SoC register bus. It receives command frames as bytes from the UART receiver and decodes them into single-cycle register reads and writes. It drives the shared addr/wr_en/rd_en/wdata bus and the per-block decoder legs, then returns an acknowledge byte and any read data to the UART transmitter. It sits between the UART RX/TX byte interfaces and the RGF blocks.

---
 rtl/rgf_master_pkg.sv | 22 ++
 rtl/rgf_uart_master_if.sv | 28 ++
 rtl/rgf_resp_sender.sv | 61 ++++++
 rtl/rgf_uart_master.sv | 187 ++++++++++++++++++
 tb/tb_rgf_uart_master.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgf_master_pkg.sv
// Shared constants and FSM state type for the UART register-bus master.
package rgf_master_pkg;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    localparam int ABYTE_BLK_MSB  = 7;
    localparam int ABYTE_BLK_LSB  = 4;
    localparam int ABYTE_ADDR_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_SEND_ACK,
        ST_SEND_DATA,
        ST_ERR_RESP
    } state_e;
endpackage

// File: rtl/rgf_uart_master_if.sv
// UART byte streams plus the shared register bus driven by the master.
interface rgf_uart_master_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BLOCKS = 4
);
    logic [7:0]                       rx_data;
    logic                             rx_valid;
    logic [7:0]                       tx_data;
    logic                             tx_valid;
    logic                             tx_ready;
    logic [ADDR_WIDTH-1:0]            bus_addr;
    logic                             bus_wr_en;
    logic                             bus_rd_en;
    logic [DATA_WIDTH-1:0]            bus_wdata;
    logic [NUM_BLOCKS-1:0]            bus_sel;
    logic [NUM_BLOCKS*DATA_WIDTH-1:0] bus_rdata;

    modport master (
        input  rx_data, rx_valid, tx_ready, bus_rdata,
        output tx_data, tx_valid, bus_addr, bus_wr_en, bus_rd_en, bus_wdata, bus_sel
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, bus_rdata,
        input  tx_data, tx_valid, bus_addr, bus_wr_en, bus_rd_en, bus_wdata, bus_sel
    );
endinterface

// File: rtl/rgf_resp_sender.sv
// Response byte sequencer: emits an ack byte, optionally followed by a
// 32-bit word MSB first, over a valid/ready handshake.
module rgf_resp_sender (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  load_ack,
    input  logic [31:0] load_data,
    input  logic        load_five,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        fire,
    output logic        done
);
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic [31:0] shift_q, shift_d;
    logic [2:0]  remain_q, remain_d;

    assign fire     = valid_q && tx_ready;
    assign done     = fire && (remain_q == 3'd0);
    assign tx_data  = byte_q;
    assign tx_valid = valid_q;

    always_comb begin
        byte_d   = byte_q;
        valid_d  = valid_q;
        shift_d  = shift_q;
        remain_d = remain_q;
        if (load) begin
            byte_d   = load_ack;
            valid_d  = 1'b1;
            shift_d  = load_data;
            remain_d = load_five ? 3'd4 : 3'd0;
        end else if (fire) begin
            if (remain_q == 3'd0) begin
                valid_d = 1'b0;
                byte_d  = '0;
            end else begin
                byte_d   = shift_q[31:24];
                shift_d  = {shift_q[23:0], 8'h00};
                remain_d = remain_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q   <= '0;
            valid_q  <= 1'b0;
            shift_q  <= '0;
            remain_q <= '0;
        end else begin
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            shift_q  <= shift_d;
            remain_q <= remain_d;
        end
    end
endmodule

// File: rtl/rgf_uart_master.sv
// UART command frames to single-cycle register bus accesses, with K/E responses.
// state      | meaning
// IDLE       | waiting for opcode byte
// GET_ADDR   | waiting for address byte
// GET_DATA   | collecting 4 write data bytes
// BUS_WR/RD  | one-cycle bus strobe, response loaded
// SEND_ACK   | 'K' in flight
// SEND_DATA  | read data bytes in flight
// ERR_RESP   | 'E' in flight
module rgf_uart_master
    import rgf_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_BLOCKS     = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               rst_n,
    rgf_uart_master_if.master  bus,
    output logic               cmd_ok,
    output logic               cmd_err,
    output logic               rx_drop
);
    localparam int              TMO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]      NUM_BLK5 = 5'(NUM_BLOCKS);

    state_e                state_q, state_d;
    logic [3:0]            blk_q, blk_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  is_wr_q, is_wr_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;

    logic                  snd_load, snd_five, snd_fire, snd_done;
    logic [7:0]            snd_ack;
    logic [DATA_WIDTH-1:0] rdata_sel;
    logic [3:0]            rx_blk;
    logic                  bus_act;

    assign rx_blk  = bus.rx_data[ABYTE_BLK_MSB:ABYTE_BLK_LSB];
    assign bus_act = (state_q == ST_BUS_WR) || (state_q == ST_BUS_RD);

    always_comb begin
        rdata_sel = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            if (blk_q == 4'(k)) rdata_sel = bus.bus_rdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        bus.bus_sel = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            bus.bus_sel[k] = bus_act && (blk_q == 4'(k));
        end
    end

    assign bus.bus_wr_en = (state_q == ST_BUS_WR);
    assign bus.bus_rd_en = (state_q == ST_BUS_RD);
    assign bus.bus_addr  = bus_act ? addr_q : '0;
    assign bus.bus_wdata = (state_q == ST_BUS_WR) ? wdata_q : '0;

    assign rx_drop = bus.rx_valid && (state_q inside {ST_BUS_WR, ST_BUS_RD, ST_SEND_ACK,
                                                      ST_SEND_DATA, ST_ERR_RESP});
    assign cmd_ok  = snd_done && ((state_q == ST_SEND_ACK) || (state_q == ST_SEND_DATA));
    assign cmd_err = snd_done && (state_q == ST_ERR_RESP);

    always_comb begin
        state_d  = state_q;
        blk_d    = blk_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        is_wr_d  = is_wr_q;
        tmo_d    = (tmo_q != '0) ? tmo_q - TMO_W'(1) : tmo_q;
        snd_load = 1'b0;
        snd_ack  = RSP_ACK;
        snd_five = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    tmo_d = TMO_LOAD;
                    if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                        is_wr_d = (bus.rx_data == OP_WRITE);
                        state_d = ST_GET_ADDR;
                    end else begin
                        snd_load = 1'b1;
                        snd_ack  = RSP_ERR;
                        state_d  = ST_ERR_RESP;
                    end
                end
            end
            ST_GET_ADDR: begin
                // An arriving byte beats the timeout on the same cycle.
                if (bus.rx_valid) begin
                    blk_d  = rx_blk;
                    addr_d = bus.rx_data[ABYTE_ADDR_LSB +: ADDR_WIDTH];
                    tmo_d  = TMO_LOAD;
                    cnt_d  = 2'd0;
                    if (is_wr_q) begin
                        state_d = ST_GET_DATA;
                    end else if ({1'b0, rx_blk} >= NUM_BLK5) begin
                        snd_load = 1'b1;
                        snd_ack  = RSP_ERR;
                        state_d  = ST_ERR_RESP;
                    end else begin
                        state_d = ST_BUS_RD;
                    end
                end else if (tmo_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_DATA: begin
                if (bus.rx_valid) begin
                    wdata_d = {wdata_q[DATA_WIDTH-9:0], bus.rx_data};
                    tmo_d   = TMO_LOAD;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if ({1'b0, blk_q} >= NUM_BLK5) begin
                            snd_load = 1'b1;
                            snd_ack  = RSP_ERR;
                            state_d  = ST_ERR_RESP;
                        end else begin
                            state_d = ST_BUS_WR;
                        end
                    end
                end else if (tmo_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS_WR: begin
                snd_load = 1'b1;
                state_d  = ST_SEND_ACK;
            end
            ST_BUS_RD: begin
                // Read data is captured straight into the sender's shift register.
                snd_load = 1'b1;
                snd_five = 1'b1;
                state_d  = ST_SEND_ACK;
            end
            ST_SEND_ACK: begin
                if (snd_done)      state_d = ST_IDLE;
                else if (snd_fire) state_d = ST_SEND_DATA;
            end
            ST_SEND_DATA, ST_ERR_RESP: begin
                if (snd_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            blk_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            tmo_q   <= tmo_d;
        end
    end

    rgf_resp_sender u_sender (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (snd_load),
        .load_ack  (snd_ack),
        .load_data (rdata_sel),
        .load_five (snd_five),
        .tx_data   (bus.tx_data),
        .tx_valid  (bus.tx_valid),
        .tx_ready  (bus.tx_ready),
        .fire      (snd_fire),
        .done      (snd_done)
    );
endmodule

// File: tb/tb_rgf_uart_master.sv
// Bench for rgf_uart_master: frame table, randomized frames against a frame-level model,
// and hand sequences for timeout, backpressure and reset.
module tb_rgf_uart_master;
    logic clk = 1'b0;
    logic rst_n;
    logic cmd_ok, cmd_err, rx_drop;
    always #5 clk = ~clk;

    rgf_uart_master_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_BLOCKS(4)) u_if ();

    rgf_uart_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_BLOCKS(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(u_if.master),
        .cmd_ok(cmd_ok), .cmd_err(cmd_err), .rx_drop(rx_drop)
    );

    logic [31:0] mem [4][16];
    for (genvar g = 0; g < 4; g++) begin : g_rdata
        assign u_if.bus_rdata[g*32 +: 32] = mem[g][u_if.bus_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  tx_log [$];
    logic [40:0] txn_log [$];
    int          rise_log [$];
    int m_ok = 0, m_err = 0, m_drop = 0, viol_bus = 0, viol_stable = 0, last_rx_cyc = 0;
    logic prev_stall = 1'b0, prev_txv = 1'b0;
    logic [7:0] prev_tx = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_txv   = 1'b0;
        end else begin
            if (u_if.tx_valid && u_if.tx_ready) tx_log.push_back(u_if.tx_data);
            if (u_if.tx_valid && !prev_txv) rise_log.push_back(cyc);
            if (prev_stall && (!u_if.tx_valid || u_if.tx_data != prev_tx)) viol_stable++;
            prev_stall = u_if.tx_valid && !u_if.tx_ready;
            prev_tx    = u_if.tx_data;
            prev_txv   = u_if.tx_valid;
            if (u_if.rx_valid) last_rx_cyc = cyc;
            if (u_if.bus_wr_en || u_if.bus_rd_en) begin
                if ((u_if.bus_wr_en && u_if.bus_rd_en) || $countones(u_if.bus_sel) != 1) viol_bus++;
                txn_log.push_back({u_if.bus_wr_en, u_if.bus_sel, u_if.bus_addr,
                                   u_if.bus_wr_en ? u_if.bus_wdata : 32'h0});
            end else if (u_if.bus_sel != 0 || u_if.bus_addr != 0 || u_if.bus_wdata != 0) begin
                viol_bus++;
            end
            if (cmd_ok)  m_ok++;
            if (cmd_err) m_err++;
            if (rx_drop) m_drop++;
        end
    end

    int rdy_mode = 0;
    initial begin
        u_if.tx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       u_if.tx_ready = 1'b1;
                1:       u_if.tx_ready = ($urandom_range(0, 3) != 0);
                default: u_if.tx_ready = 1'b0;
            endcase
        end
    end

    int n_chk = 0, n_pass = 0;
    int s_tx, s_txn, s_ok, s_err, s_drop, s_rise;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] outs();
        return {10'b0, u_if.tx_valid, u_if.tx_data, u_if.bus_wr_en, u_if.bus_rd_en, u_if.bus_addr,
                u_if.bus_wdata, u_if.bus_sel, cmd_ok, cmd_err, rx_drop};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        @(posedge clk); #1;
        u_if.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] fr, input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            send_byte(fr[8*(n-1-i) +: 8]);
            if (maxgap > 0 && i < n - 1) idle($urandom_range(0, maxgap));
        end
    endtask

    task automatic snap();
        s_tx = tx_log.size(); s_txn = txn_log.size(); s_ok = m_ok; s_err = m_err;
        s_drop = m_drop; s_rise = rise_log.size();
    endtask

    task automatic wait_done();
        int b = 0;
        while (m_ok == s_ok && m_err == s_err && b < 400) begin
            @(posedge clk); #1;
            b++;
        end
        idle(1);
    endtask

    task automatic wait_txv();
        int b = 0;
        while (!u_if.tx_valid && b < 50) begin
            @(posedge clk); #1;
            b++;
        end
    endtask

    // Frame-level reference: what the bridge should answer and put on the bus.
    task automatic model(input logic [47:0] fr, input int n, output int nresp, output logic [39:0] resp,
                         output int ntxn, output logic [40:0] txn, output int ok, output int err);
        logic [7:0] op, ab;
        int blk, a;
        op = fr[8*(n-1) +: 8];
        nresp = 1; resp = 40'h45; ntxn = 0; txn = '0; ok = 0; err = 1;
        if (n < 2 || (op != 8'h57 && op != 8'h52)) return;
        ab = fr[8*(n-2) +: 8];
        blk = ab / 16;
        a = ab % 16;
        if (blk >= 4) return;
        ok = 1; err = 0; ntxn = 1;
        if (op == 8'h57) begin
            resp = 40'h4B;
            txn  = {1'b1, 4'(1 << blk), 4'(a), fr[31:0]};
        end else begin
            nresp = 5;
            resp  = {8'h4B, mem[blk][a]};
            txn   = {1'b0, 4'(1 << blk), 4'(a), 32'h0};
        end
    endtask

    task automatic check_frame(input string tag, input int nresp, input logic [39:0] resp, input int ntxn,
                               input logic [40:0] txn, input int ok, input int err);
        logic [39:0] pk = '0;
        for (int i = s_tx; i < tx_log.size(); i++) pk = {pk[31:0], tx_log[i]};
        check({tag, " tx_count"}, 64'(tx_log.size() - s_tx), 64'(nresp));
        check({tag, " tx_bytes"}, 64'(pk), 64'(resp));
        check({tag, " strobe_count"}, 64'(txn_log.size() - s_txn), 64'(ntxn));
        if (ntxn == 1 && txn_log.size() > s_txn) check({tag, " strobe_fields"}, 64'(txn_log[s_txn]), 64'(txn));
        check({tag, " cmd_ok"}, 64'(m_ok - s_ok), 64'(ok));
        check({tag, " cmd_err"}, 64'(m_err - s_err), 64'(err));
    endtask

    task automatic run_model_frame(input string tag, input logic [47:0] fr, input int n, input int maxgap);
        int nresp, ntxn, ok, err;
        logic [39:0] resp;
        logic [40:0] txn;
        snap();
        send_frame(fr, n, maxgap);
        wait_done();
        model(fr, n, nresp, resp, ntxn, txn, ok, err);
        check_frame(tag, nresp, resp, ntxn, txn, ok, err);
    endtask

    typedef struct {
        logic [47:0] fr;
        int          n;
        int          nresp;
        logic [39:0] resp;
        int          ntxn;
        logic [40:0] txn;
        int          ok;
        int          err;
        int          lat;
    } vec_t;
    vec_t tbl [7];

    initial begin
        int nresp, ntxn, ok, err;
        logic [39:0] resp;
        logic [40:0] txn;
        logic [47:0] fr;
        logic [7:0]  op;
        logic [3:0]  bk;
        int          n, kind;

        for (int k = 0; k < 4; k++)
            for (int a = 0; a < 16; a++) mem[k][a] = $urandom;
        mem[0][8]  = 32'h0000_0005;
        mem[2][10] = 32'hCAFE_F00D;

        tbl[0] = '{48'h57_14_DE_AD_BE_EF, 6, 1, 40'h4B, 1, {1'b1, 4'b0010, 4'h4, 32'hDEADBEEF}, 1, 0, 2};
        tbl[1] = '{48'h52_08, 2, 5, 40'h4B_00_00_00_05, 1, {1'b0, 4'b0001, 4'h8, 32'h0}, 1, 0, 2};
        tbl[2] = '{48'h99, 1, 1, 40'h45, 0, 41'h0, 0, 1, 1};
        tbl[3] = '{48'h57_F0_11_22_33_44, 6, 1, 40'h45, 0, 41'h0, 0, 1, 1};
        tbl[4] = '{48'h52_50, 2, 1, 40'h45, 0, 41'h0, 0, 1, 1};
        tbl[5] = '{48'h57_3F_01_02_03_04, 6, 1, 40'h4B, 1, {1'b1, 4'b1000, 4'hF, 32'h01020304}, 1, 0, 2};
        tbl[6] = '{48'h52_2A, 2, 5, 40'h4B_CA_FE_F0_0D, 1, {1'b0, 4'b0100, 4'hA, 32'h0}, 1, 0, 2};

        rst_n = 1'b0;
        u_if.rx_valid = 1'b0;
        u_if.rx_data  = '0;
        idle(3);
        check("reset_outputs", outs(), 64'h0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 7; i++) begin
            snap();
            send_frame(tbl[i].fr, tbl[i].n, 0);
            wait_done();
            check_frame($sformatf("vec%0d", i), tbl[i].nresp, tbl[i].resp, tbl[i].ntxn, tbl[i].txn,
                        tbl[i].ok, tbl[i].err);
            check($sformatf("vec%0d latency", i),
                  64'((rise_log.size() > s_rise) ? rise_log[s_rise] - last_rx_cyc : -1), 64'(tbl[i].lat));
        end

        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            bk   = 4'($urandom_range(0, 5));
            if (kind == 0) begin
                do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
                fr = {40'h0, op}; n = 1;
            end else if (kind < 5) begin
                fr = {8'h57, bk, 4'($urandom), 32'($urandom)}; n = 6;
            end else begin
                fr = {32'h0, 8'h52, bk, 4'($urandom)}; n = 2;
            end
            run_model_frame($sformatf("rnd%0d", i), fr, n, 3);
        end
        rdy_mode = 0;
        idle(2);

        snap();
        send_frame(48'h57_04_11, 3, 0);
        idle(20);
        check("timeout tx_count", 64'(tx_log.size() - s_tx), 64'd0);
        check("timeout strobes", 64'(txn_log.size() - s_txn), 64'd0);
        check("timeout cmd_err", 64'(m_err - s_err), 64'd0);
        run_model_frame("after_timeout", 48'h52_04, 2, 0);

        snap();
        send_byte(8'h57); idle(12); send_byte(8'h21);
        for (int i = 0; i < 4; i++) begin
            idle(12);
            send_byte(8'(8'hA0 + i));
        end
        wait_done();
        check_frame("slow_write", 1, 40'h4B, 1, {1'b1, 4'b0100, 4'h1, 32'hA0A1A2A3}, 1, 0);

        rdy_mode = 2;
        snap();
        send_frame(48'h52_31, 2, 0);
        wait_txv();
        send_byte(8'h57); idle(1); send_byte(8'h52); idle(2);
        check("stall rx_drop", 64'(m_drop - s_drop), 64'd2);
        check("stall no_handshake", 64'(tx_log.size() - s_tx), 64'd0);
        rdy_mode = 0;
        wait_done();
        model(48'h52_31, 2, nresp, resp, ntxn, txn, ok, err);
        check_frame("stall_read", nresp, resp, ntxn, txn, ok, err);
        run_model_frame("after_stall", 48'h52_08, 2, 0);

        send_frame(48'h57_04_AA, 3, 0);
        rst_n = 1'b0;
        #2;
        check("reset_mid_frame", outs(), 64'h0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        run_model_frame("after_reset", 48'h52_04, 2, 0);

        rdy_mode = 2;
        send_frame(48'h52_0C, 2, 0);
        wait_txv();
        rst_n = 1'b0;
        #2;
        check("reset_stalled_tx", outs(), 64'h0);
        rdy_mode = 0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        run_model_frame("after_reset2", 48'h52_2A, 2, 0);

        check("idle_bus_and_strobe_shape", 64'(viol_bus), 64'd0);
        check("tx_hold_while_stalled", 64'(viol_stable), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
